// File: rtl/audio_playback_controller_if.sv
// Host control, sample RAM and serializer signals
// of the audio playback controller.
interface audio_playback_controller_if #(
  parameter int WORD_LENGTH = 16,
  parameter int ADDR_WIDTH  = 10
);
  logic                   start_i;
  logic                   stop_i;
  logic                   loop_i;
  logic [ADDR_WIDTH:0]    length_i;
  logic                   mem_rd_o;
  logic [ADDR_WIDTH-1:0]  mem_addr_o;
  logic [WORD_LENGTH-1:0] mem_data_i;
  logic                   ser_enable_o;
  logic [WORD_LENGTH-1:0] ser_data_o;
  logic                   ser_done_i;
  logic                   busy_o;
  logic                   done_o;
  logic                   underrun_o;
  logic [ADDR_WIDTH-1:0]  play_index_o;

  modport master (
    input  start_i, stop_i, loop_i, length_i,
    input  mem_data_i, ser_done_i,
    output mem_rd_o, mem_addr_o,
    output ser_enable_o, ser_data_o,
    output busy_o, done_o, underrun_o, play_index_o
  );

  modport slave (
    output start_i, stop_i, loop_i, length_i,
    output mem_data_i, ser_done_i,
    input  mem_rd_o, mem_addr_o,
    input  ser_enable_o, ser_data_o,
    input  busy_o, done_o, underrun_o, play_index_o
  );
endinterface

// File: rtl/audio_playback_controller.sv
// Streams sample RAM words into the PWM serializer,
// prefetching one word ahead for gapless playback.
module audio_playback_controller #(
  parameter int WORD_LENGTH = 16,
  parameter int ADDR_WIDTH  = 10
) (
  input logic clock_i,
  input logic reset_i,
  audio_playback_controller_if.master bus
);
  localparam int CW = ADDR_WIDTH + 1;
  localparam logic [CW-1:0] DEPTH = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [CW-1:0] ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    IDLE, FETCH, LOAD, RUN, STALL
  } state_t;

  state_t state_q, state_d;
  logic [CW-1:0] len_q, len_d;
  logic [CW-1:0] faddr_q, faddr_d;
  logic [CW-1:0] fcnt_q, fcnt_d;
  logic loop_q, loop_d;
  logic infl_q, infl_d;
  logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
  logic [WORD_LENGTH-1:0] pend_q, pend_d;
  logic [ADDR_WIDTH-1:0] pend_addr_q, pend_addr_d;
  logic pend_full_q, pend_full_d;
  logic [WORD_LENGTH-1:0] data_q, data_d;
  logic [ADDR_WIDTH-1:0] pidx_q, pidx_d;
  logic en_q, en_d;
  logic done_q, done_d;
  logic und_q, und_d;

  logic [CW-1:0] len_clamp, faddr_nxt;
  logic due, can_fetch, issue, adv;

  always_comb begin
    len_clamp = (bus.length_i > DEPTH) ? DEPTH : bus.length_i;
    due = loop_q || (fcnt_q < len_q);
    can_fetch = due && !pend_full_q && !infl_q;
    faddr_nxt = (loop_q && faddr_q == len_q - ONE)
              ? '0 : faddr_q + ONE;
    issue = can_fetch && !bus.stop_i &&
            (state_q == RUN || state_q == STALL);
    adv = issue || (state_q == FETCH && !bus.stop_i);
  end

  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    loop_d      = loop_q;
    faddr_d     = faddr_q;
    fcnt_d      = fcnt_q;
    infl_d      = issue;
    rd_addr_d   = rd_addr_q;
    pend_d      = pend_q;
    pend_addr_d = pend_addr_q;
    pend_full_d = pend_full_q;
    data_d      = data_q;
    pidx_d      = pidx_q;
    en_d        = en_q;
    done_d      = 1'b0;
    und_d       = und_q;

    if (adv) begin
      rd_addr_d = faddr_q[ADDR_WIDTH-1:0];
      faddr_d   = faddr_nxt;
      fcnt_d    = fcnt_q + ONE;
    end

    // Prefetch data lands one cycle after its strobe.
    if (infl_q) begin
      pend_d      = bus.mem_data_i;
      pend_addr_d = rd_addr_q;
      pend_full_d = 1'b1;
    end

    unique case (state_q)
      IDLE: begin
        if (bus.start_i && !bus.stop_i && len_clamp != '0) begin
          len_d   = len_clamp;
          loop_d  = bus.loop_i;
          faddr_d = '0;
          fcnt_d  = '0;
          und_d   = 1'b0;
          state_d = FETCH;
        end
      end
      FETCH: state_d = LOAD;
      LOAD: begin
        data_d  = bus.mem_data_i;
        pidx_d  = '0;
        en_d    = 1'b1;
        state_d = RUN;
      end
      RUN: begin
        if (bus.ser_done_i) begin
          if (pend_full_q) begin
            data_d      = pend_q;
            pidx_d      = pend_addr_q;
            pend_full_d = 1'b0;
          end else if (!due && !infl_q) begin
            en_d    = 1'b0;
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            en_d    = 1'b0;
            und_d   = 1'b1;
            state_d = STALL;
          end
        end
      end
      STALL: begin
        if (pend_full_q) begin
          data_d      = pend_q;
          pidx_d      = pend_addr_q;
          pend_full_d = 1'b0;
          en_d        = 1'b1;
          state_d     = RUN;
        end
      end
      default: state_d = IDLE;
    endcase

    // Abort overrides any swap or completion on the same edge.
    if (state_q != IDLE && bus.stop_i) begin
      state_d     = IDLE;
      en_d        = 1'b0;
      done_d      = 1'b0;
      und_d       = und_q;
      infl_d      = 1'b0;
      pend_full_d = 1'b0;
      data_d      = data_q;
      pidx_d      = pidx_q;
    end
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state_q     <= IDLE;
      len_q       <= '0;
      loop_q      <= 1'b0;
      faddr_q     <= '0;
      fcnt_q      <= '0;
      infl_q      <= 1'b0;
      rd_addr_q   <= '0;
      pend_q      <= '0;
      pend_addr_q <= '0;
      pend_full_q <= 1'b0;
      data_q      <= '0;
      pidx_q      <= '0;
      en_q        <= 1'b0;
      done_q      <= 1'b0;
      und_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      loop_q      <= loop_d;
      faddr_q     <= faddr_d;
      fcnt_q      <= fcnt_d;
      infl_q      <= infl_d;
      rd_addr_q   <= rd_addr_d;
      pend_q      <= pend_d;
      pend_addr_q <= pend_addr_d;
      pend_full_q <= pend_full_d;
      data_q      <= data_d;
      pidx_q      <= pidx_d;
      en_q        <= en_d;
      done_q      <= done_d;
      und_q       <= und_d;
    end
  end

  assign bus.mem_rd_o     = adv;
  assign bus.mem_addr_o   = faddr_q[ADDR_WIDTH-1:0];
  assign bus.ser_enable_o = en_q;
  assign bus.ser_data_o   = data_q;
  assign bus.busy_o       = (state_q != IDLE);
  assign bus.done_o       = done_q;
  assign bus.underrun_o   = und_q;
  assign bus.play_index_o = pidx_q;
endmodule

// File: tb/tb_audio_playback_controller.sv
// Bench for audio_playback_controller: RAM and serializer
// models plus a word-level playback scoreboard.
module tb_audio_playback_controller;
  localparam int W = 16;
  localparam int AW = 10;
  localparam int DEPTH = 1024;

  logic clk = 1'b0;
  logic rst = 1'b0;

  audio_playback_controller_if #(
    .WORD_LENGTH(W), .ADDR_WIDTH(AW)
  ) bus ();

  audio_playback_controller #(
    .WORD_LENGTH(W), .ADDR_WIDTH(AW)
  ) dut (
    .clock_i(clk),
    .reset_i(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  logic [W-1:0] ram [DEPTH];

  bit trk, m_loop, need_log, started, seen_en, last_en;
  int m_len, exp_idx, played, fa, n_reads;
  int en_drop, busy_low, done_cnt, ser_period, ser_cnt;
  bit rd_lat;
  logic [AW-1:0] rd_addr_lat;
  int idx_log[$];
  logic [W-1:0] dat_log[$];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, need %0h", nm, act, exp);
    end
  endtask

  task automatic cycle_check();
    bit fin;
    fin = 1'b0;
    if (trk && bus.ser_done_i && last_en) begin
      played++;
      if (!m_loop && played == m_len) begin
        fin = 1'b1;
        trk = 1'b0;
      end else begin
        exp_idx = (exp_idx + 1 >= m_len) ? 0 : exp_idx + 1;
        need_log = 1'b1;
      end
    end
    chk("done_o", bus.done_o, fin);
    if (bus.done_o) done_cnt++;
    if (fin) begin
      chk("end busy", bus.busy_o, 0);
      chk("end enable", bus.ser_enable_o, 0);
    end
    if (trk && bus.ser_enable_o) begin
      seen_en = 1'b1;
      chk("play_index", bus.play_index_o, exp_idx);
      chk("ser_data", bus.ser_data_o, ram[exp_idx]);
      if (need_log) begin
        idx_log.push_back(int'(bus.play_index_o));
        dat_log.push_back(bus.ser_data_o);
        need_log = 1'b0;
      end
    end
    if (trk && seen_en && !bus.ser_enable_o) en_drop++;
    if (trk && started && !bus.busy_o) busy_low++;
    if (trk && bus.mem_rd_o) begin
      if (!m_loop) chk("read budget", n_reads < m_len, 1);
      chk("mem_addr", bus.mem_addr_o, fa);
      n_reads++;
      fa = (fa + 1 >= m_len) ? 0 : fa + 1;
    end
    last_en = bus.ser_enable_o;
    if (rd_lat) bus.mem_data_i = ram[rd_addr_lat];
    rd_lat = bus.mem_rd_o;
    rd_addr_lat = bus.mem_addr_o;
    if (bus.ser_enable_o) begin
      ser_cnt++;
      bus.ser_done_i = (ser_cnt >= ser_period);
      if (bus.ser_done_i) ser_cnt = 0;
    end else begin
      ser_cnt = 0;
      bus.ser_done_i = 1'b0;
    end
  endtask

  task automatic start_run(input int len_in, input bit lp,
                           input int per);
    @(posedge clk);
    #2;
    ser_period = per;
    m_len = (len_in > DEPTH) ? DEPTH : len_in;
    m_loop = lp;
    exp_idx = 0; played = 0; fa = 0; n_reads = 0;
    en_drop = 0; busy_low = 0; done_cnt = 0;
    seen_en = 1'b0; started = 1'b0; need_log = 1'b1;
    idx_log.delete();
    dat_log.delete();
    trk = (m_len != 0);
    bus.start_i = 1'b1;
    bus.loop_i = lp;
    bus.length_i = 11'(len_in);
    @(posedge clk);
    #1;
    bus.start_i = 1'b0;
    started = 1'b1;
  endtask

  task automatic wait_idle(input int budget, input string nm);
    int n;
    n = 0;
    while (trk && n < budget) begin
      @(posedge clk);
      n++;
    end
    #2;
    chk({nm, " timeout"}, trk, 0);
  endtask

  task automatic chk_outs_zero(input string nm);
    chk({nm, " busy"}, bus.busy_o, 0);
    chk({nm, " enable"}, bus.ser_enable_o, 0);
    chk({nm, " data"}, bus.ser_data_o, 0);
    chk({nm, " index"}, bus.play_index_o, 0);
    chk({nm, " done"}, bus.done_o, 0);
    chk({nm, " underrun"}, bus.underrun_o, 0);
    chk({nm, " rd"}, bus.mem_rd_o, 0);
    chk({nm, " addr"}, bus.mem_addr_o, 0);
  endtask

  initial begin
    logic [W-1:0] t1w [3];
    int t2i [5];
    int n, rdc;
    t1w[0] = 16'hAAAA; t1w[1] = 16'h5555; t1w[2] = 16'h1234;
    t2i[0] = 0; t2i[1] = 1; t2i[2] = 0; t2i[3] = 1; t2i[4] = 0;
    bus.start_i = 1'b0;
    bus.stop_i = 1'b0;
    bus.loop_i = 1'b0;
    bus.length_i = '0;
    bus.mem_data_i = '0;
    bus.ser_done_i = 1'b0;
    trk = 1'b0; last_en = 1'b0; rd_lat = 1'b0;
    ser_cnt = 0; ser_period = 1600; done_cnt = 0;
    for (int i = 0; i < DEPTH; i++) ram[i] = 16'($urandom);
    #1 rst = 1'b1;
    #1 chk_outs_zero("reset");
    fork
      forever begin
        @(negedge clk);
        cycle_check();
      end
    join_none
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;

    // one-shot length 3 with literal latency points
    ram[0] = 16'hAAAA; ram[1] = 16'h5555; ram[2] = 16'h1234;
    start_run(3, 1'b0, 1600);
    chk("t1 fetch busy", bus.busy_o, 1);
    chk("t1 fetch rd", bus.mem_rd_o, 1);
    chk("t1 fetch addr", bus.mem_addr_o, 0);
    chk("t1 fetch en", bus.ser_enable_o, 0);
    @(posedge clk); #1;
    chk("t1 load rd", bus.mem_rd_o, 0);
    chk("t1 load en", bus.ser_enable_o, 0);
    @(posedge clk); #1;
    chk("t1 run en", bus.ser_enable_o, 1);
    chk("t1 run data", bus.ser_data_o, 16'hAAAA);
    chk("t1 prefetch rd", bus.mem_rd_o, 1);
    chk("t1 prefetch addr", bus.mem_addr_o, 1);
    wait_idle(6000, "t1");
    chk("t1 words", dat_log.size(), 3);
    for (int i = 0; i < 3; i++)
      chk("t1 word", (i < dat_log.size()) ? 32'(dat_log[i])
                                          : 32'hDEAD_BEEF, t1w[i]);
    chk("t1 en drop", en_drop, 0);
    chk("t1 done pulses", done_cnt, 1);
    chk("t1 underrun", bus.underrun_o, 0);
    chk("t1 reads", n_reads, 3);

    // looped length 2, stopped after five words
    ram[0] = 16'h0001; ram[1] = 16'h0002;
    start_run(2, 1'b1, 20);
    n = 0;
    while (played < 5 && n < 400) begin
      @(posedge clk);
      n++;
    end
    #2;
    chk("t2 plays", played >= 5, 1);
    bus.stop_i = 1'b1;
    trk = 1'b0;
    @(posedge clk); #1;
    chk("t2 stop busy", bus.busy_o, 0);
    chk("t2 stop en", bus.ser_enable_o, 0);
    chk("t2 stop done", bus.done_o, 0);
    bus.stop_i = 1'b0;
    for (int i = 0; i < 5; i++)
      chk("t2 index", (i < idx_log.size()) ? idx_log[i] : -1, t2i[i]);
    chk("t2 busy low", busy_low, 0);
    chk("t2 en drop", en_drop, 0);
    chk("t2 done pulses", done_cnt, 0);

    // length 0 is ignored
    start_run(0, 1'b0, 20);
    chk("t3 busy", bus.busy_o, 0);
    rdc = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (bus.mem_rd_o) rdc++;
    end
    chk("t3 reads", rdc, 0);
    chk("t3 done pulses", done_cnt, 0);
    chk("t3 still idle", bus.busy_o, 0);

    // serializer too fast: underrun and stall
    ram[0] = 16'hAAAA; ram[1] = 16'h5555; ram[2] = 16'h1234;
    start_run(3, 1'b0, 2);
    n = 0;
    while (!bus.underrun_o && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    chk("t4 underrun set", bus.underrun_o, 1);
    chk("t4 stall en", bus.ser_enable_o, 0);
    chk("t4 stall busy", bus.busy_o, 1);
    wait_idle(200, "t4");
    chk("t4 underrun sticky", bus.underrun_o, 1);
    chk("t4 words", dat_log.size(), 3);
    for (int i = 0; i < 3; i++)
      chk("t4 word", (i < dat_log.size()) ? 32'(dat_log[i])
                                          : 32'hDEAD_BEEF, t1w[i]);
    chk("t4 done pulses", done_cnt, 1);

    // next start clears underrun
    start_run(3, 1'b0, 10);
    chk("t5 underrun clear", bus.underrun_o, 0);
    wait_idle(200, "t5");
    chk("t5 underrun", bus.underrun_o, 0);
    chk("t5 en drop", en_drop, 0);
    chk("t5 done pulses", done_cnt, 1);

    // one-shot length 1
    start_run(1, 1'b0, 10);
    wait_idle(100, "t6");
    chk("t6 reads", n_reads, 1);
    chk("t6 words", dat_log.size(), 1);
    chk("t6 done pulses", done_cnt, 1);

    // full depth and clamped over-length
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < DEPTH; i++) ram[i] = 16'($urandom);
      start_run((k == 0) ? 1024 : 2047, 1'b0, 6);
      wait_idle(8000, "t7");
      chk("t7 words", idx_log.size(), 1024);
      chk("t7 first", (idx_log.size() > 0) ? idx_log[0] : -1, 0);
      chk("t7 last", (idx_log.size() == 1024) ? idx_log[1023] : -1,
          1023);
      chk("t7 reads", n_reads, 1024);
      chk("t7 done pulses", done_cnt, 1);
      chk("t7 en drop", en_drop, 0);
    end

    // asynchronous reset mid-word, then replay
    ram[0] = 16'hBEEF; ram[1] = 16'hCAFE;
    start_run(2, 1'b0, 20);
    repeat (6) @(posedge clk);
    #2;
    trk = 1'b0;
    rst = 1'b1;
    #1 chk_outs_zero("t8 reset");
    @(posedge clk);
    #2 rst = 1'b0;
    start_run(2, 1'b0, 20);
    wait_idle(200, "t8");
    chk("t8 words", idx_log.size(), 2);
    chk("t8 first idx", (idx_log.size() > 0) ? idx_log[0] : -1, 0);
    chk("t8 first word",
        (dat_log.size() > 0) ? 32'(dat_log[0]) : 32'hDEAD_BEEF,
        16'hBEEF);
    chk("t8 done pulses", done_cnt, 1);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/audio_playback_controller.md
# audio_playback_controller

Sequences stored audio samples into the PWM serializer. Reads 16-bit words from a synchronous sample RAM and presents them to the serializer. It holds the serializer's enable high across word boundaries and swaps in a prefetched word on each serializer done pulse. It supports one-shot and looped playback of a programmable sample count, plus abort and underrun reporting.

## Interface
- WORD_LENGTH, 16, sample word width; must match the serializer.
- ADDR_WIDTH, 10, sample RAM address width; RAM depth is 2^ADDR_WIDTH.
- clock_i  in  1  system clock; all logic on rising edge.
- reset_i  in  1  asynchronous, active-high reset.
- start_i  in  1  begin playback; sampled only in IDLE.
- stop_i  in  1  abort playback; acts in any non-IDLE state.
- loop_i  in  1  wrap to address 0 after the last sample; sampled with start_i.
- length_i  in  ADDR_WIDTH+1  number of samples to play; sampled with start_i; values above 2^ADDR_WIDTH are clamped to 2^ADDR_WIDTH.
- mem_rd_o  out  1  RAM read strobe, one cycle per read.
- mem_addr_o  out  ADDR_WIDTH  RAM read address, valid with mem_rd_o.
- mem_data_i  in  WORD_LENGTH  RAM read data, valid the cycle after mem_rd_o.
- ser_enable_o  out  1  serializer enable.
- ser_data_o  out  WORD_LENGTH  word being serialized; stable while ser_enable_o is high, except at swap edges.
- ser_done_i  in  1  serializer single-cycle done pulse (last bit emitted).
- busy_o  out  1  high in any state except IDLE.
- done_o  out  1  one-cycle pulse on natural completion of one-shot playback.
- underrun_o  out  1  sticky; set when a swap finds no pending word; cleared on accepted start.
- play_index_o  out  ADDR_WIDTH  RAM address of the word on ser_data_o.

## Operation
- States: IDLE, FETCH, LOAD, RUN, STALL.
- IDLE:
  - Accepted start requires start_i=1, stop_i=0 and clamped length_i≠0.
  - On accepted start: latch length and loop, set fetch address to 0, clear underrun_o, go to FETCH.
  - start_i with length 0: ignored, no done_o pulse.
- FETCH: mem_rd_o=1, mem_addr_o=0; go to LOAD.
- LOAD: capture mem_data_i into ser_data_o, set play_index_o=0, go to RUN.
- RUN:
  - ser_enable_o=1.
  - Prefetch: while the pending register is empty and another word is due, issue one read. Capture the data into pending the next cycle.
  - Another word is due if words fetched < length, or loop is set. The fetch address wraps from length-1 to 0 when loop is set.
  - On ser_done_i with pending full: at the same edge, ser_data_o ← pending, play_index_o ← pending address, pending becomes empty.
  - On ser_done_i with the last word playing and loop clear: ser_enable_o ← 0, done_o pulses, go to IDLE.
  - On ser_done_i with pending empty but a word due (including one in flight): set underrun_o, ser_enable_o ← 0, go to STALL.
- STALL:
  - ser_enable_o=0; complete or issue the outstanding read.
  - When pending is full: perform the swap, set ser_enable_o ← 1, return to RUN.
- stop_i in any non-IDLE state: go to IDLE next edge with ser_enable_o ← 0. No done_o pulse, and any in-flight read data is discarded.
- start_i while busy_o=1: ignored.
- Length 1:
  - One-shot: no prefetch; done_o pulses after the first ser_done_i.
  - Looped: prefetch re-reads address 0 each word.
- Counters are ADDR_WIDTH+1 bits; the address is the low ADDR_WIDTH bits. Full-depth length plays addresses 0 through 2^ADDR_WIDTH-1.

## Timing
- Reset values: all outputs 0, state IDLE, pending empty, counters 0.
- Start latency: start_i high at edge N.
  - FETCH during N→N+1, with mem_rd_o high.
  - LOAD during N+1→N+2.
  - ser_enable_o=1 and ser_data_o=word0 from edge N+2.
- First prefetch: mem_rd_o for address 1 is high in the first RUN cycle; pending is full two edges later.
- Swap: ser_data_o changes on the edge that samples ser_done_i=1, and ser_enable_o stays high. The serializer restarts on the next word with no gap.
- Completion: done_o is high for exactly the cycle after the edge that samples the final ser_done_i. busy_o and ser_enable_o are low in that same cycle.
- stop_i and ser_done_i sampled at the same edge: stop wins; no swap and no done_o.
- Asynchronous reset mid-operation: all outputs clear immediately; after release, the controller waits in IDLE for a new start.

## Test plan
- One-shot, length 3, RAM[0..2] = 0xAAAA, 0x5555, 0x1234, serializer model with done every 1600 cycles → ser_data_o sequence 0xAAAA, 0x5555, 0x1234; ser_enable_o never drops; a single done_o pulse; underrun_o=0.
- Loop, length 2, RAM = 0x0001, 0x0002 → play_index_o sequence 0,1,0,1,0; busy_o stays 1; stop_i after the 5th done → IDLE next edge with no done_o.
- Length 0 with start_i → stays IDLE; no mem_rd_o, no done_o.
- Serializer model pulses ser_done_i two cycles after enable → underrun_o=1, STALL with enable low; resumes with the correct next word; underrun_o clears on the next start.
- Length 1024 with ADDR_WIDTH=10, and length_i=2047 → both play exactly 1024 words, addresses 0 through 1023; done_o once.
- reset_i asserted mid-word → all outputs 0 immediately; a subsequent start replays from address 0.
